// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order
// response capture into a small {pc, inst} buffer, redirect flush.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  cnt_t            pending_q, pending_d;
  cnt_t            drop_q, drop_d;
  cnt_t            count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic [CW:0] used;
  logic        credit_ok;
  logic        req_fire;
  logic        push;
  logic        pop;

  // In-flight requests (including doomed ones) plus buffered entries
  // never exceed DEPTH, so a response always finds a free slot.
  assign used      = {1'b0, pending_q} + {1'b0, count_q};
  assign credit_ok = used < (CW+1)'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count_q != '0);
  assign out_inst  = inst_mem_q[rd_q];
  assign out_pc    = pc_mem_q[rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pending_d  = pending_q + cnt_t'(req_fire)
               - cnt_t'(imem_rsp_valid);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = pending_q - cnt_t'(imem_rsp_valid);
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (req_fire)
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && drop_q != '0)
        drop_d = drop_q - cnt_t'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wr_d     = wr_q + AW'(1);
      end
      if (pop)
        rd_d = rd_q + AW'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      pending_q  <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]   <= rsp_pc_q;
      inst_mem_q[wr_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-built corner
// sequences and a randomized run against a queue-based memory model.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory/reference model: each accepted request is remembered with its
  // address; a redirect dooms everything still in flight. Expected buffer
  // contents are simply the addresses of undoomed responses, in order.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          doomed;
  } flight_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  flight_t     memq[$];
  ent_t        fifo[$];
  logic [31:0] req_exp;
  int          cyc;
  int          lat_mode;
  int          nfire;

  task automatic do_reset();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    memq.delete();
    fifo.delete();
    req_exp = 32'h0;
    cyc     = 0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
  endtask

  task automatic step(input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic ordy);
    logic    rv;
    logic    exp_rv;
    logic    pop;
    flight_t h;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ordy;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? mem_word(memq[0].addr) : $urandom;
    #1;
    exp_rv = !redir && (memq.size() + fifo.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv)
      chk("req_addr", imem_req_addr, req_exp);
    chk("out_valid", 32'(out_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      chk("out_pc", out_pc, fifo[0].pc);
      chk("out_inst", out_inst, fifo[0].inst);
    end
    if (imem_req_valid && rdy)
      nfire++;
    pop = (fifo.size() != 0) && ordy && !redir;
    if (rv) begin
      h = memq.pop_front();
      if (!redir && !h.doomed) begin
        if (pop)
          void'(fifo.pop_front());
        pop = 1'b0;
        fifo.push_back('{pc: h.addr, inst: mem_word(h.addr)});
      end
    end
    if (redir) begin
      fifo.delete();
      foreach (memq[i]) memq[i].doomed = 1'b1;
      req_exp = {rpc[31:2], 2'b00};
    end else begin
      if (pop)
        void'(fifo.pop_front());
      if (exp_rv && rdy) begin
        memq.push_back('{addr: req_exp,
          due: cyc + ((lat_mode == 0) ? int'($urandom_range(1, 3))
                                      : lat_mode),
          doomed: 1'b0});
        req_exp = req_exp + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 0, 0, 0,                  1, 32'h0,   0, 0, 0};
    vecs[1] = '{0, 0, 1, mem_word(32'h0),    1, 32'h4,   0, 0, 0};
    vecs[2] = '{0, 0, 1, mem_word(32'h4),    1, 32'h8,   1, 32'h0,
                mem_word(32'h0)};
    vecs[3] = '{0, 0, 1, mem_word(32'h8),    1, 32'hC,   1, 32'h4,
                mem_word(32'h4)};
    vecs[4] = '{1, 32'h103, 1, mem_word(32'hC), 0, 32'h0, 1, 32'h8,
                mem_word(32'h8)};
    vecs[5] = '{0, 0, 0, 0,                  1, 32'h100, 0, 0, 0};
    vecs[6] = '{0, 0, 1, mem_word(32'h100),  1, 32'h104, 0, 0, 0};
    vecs[7] = '{0, 0, 1, mem_word(32'h104),  1, 32'h108, 1, 32'h100,
                mem_word(32'h100)};

    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    lat_mode       = 1;
    nfire          = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed table: 1-cycle memory, decode always ready
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rd;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid),
          32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk($sformatf("vec%0d_req_addr", i), imem_req_addr,
            vecs[i].e_addr);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid),
          32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].e_inst);
      end
      @(negedge clk);
    end

    // Backpressure: exactly DEPTH requests, then drain in order
    @(negedge clk);
    do_reset();
    lat_mode = 1;
    nfire    = 0;
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_accepted", 32'(nfire), 32'(DEPTH));
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);

    // 3-cycle memory, 3 in flight, misaligned redirect
    do_reset();
    lat_mode = 3;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h103, 1'b1);
    chk("redir_addr", imem_req_addr, 32'h100);
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect together with a response and a pop
    do_reset();
    lat_mode = 1;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    chk("redir_empty", 32'(out_valid), 32'd0);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Address wrap at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Reset with count=3, pending=1
    do_reset();
    lat_mode = 1;
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_out_pc", out_pc, 32'h0);
    do_reset();
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized run
    lat_mode = 0;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : $urandom;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           rpc, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, instruction buffer entries and max in-flight credit; power of 2, >= 2.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  XLEN  byte address of request, word-aligned.
REQ-009 imem_rsp_valid  input  1  response valid; in order, one per accepted request, >= 1 cycle after acceptance, no backpressure.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 redirect_valid  input  1  branch/jump taken; flush and restart.
REQ-012 redirect_pc  input  XLEN  new fetch target.
REQ-013 out_valid  output  1  instruction available to decode.
REQ-014 out_ready  input  1  decode accepts instruction.
REQ-015 out_inst  output  32  instruction at buffer head.
REQ-016 out_pc  output  XLEN  PC of out_inst.

Function
REQ-017 Registers: fetch_pc (next request address), rsp_pc (PC of oldest live in-flight request), pending (0..DEPTH, all in-flight incl. doomed), drop_cnt (0..DEPTH), count (0..DEPTH), FIFO of DEPTH {pc, inst} entries with wrapping rd/wr pointers.
REQ-018 imem_req_valid SHALL be 1 iff !rst, !redirect_valid, and pending + count < DEPTH; imem_req_addr = fetch_pc.
REQ-019 Request handshake (valid & ready): fetch_pc += 4 (mod 2^XLEN), pending += 1.
REQ-020 imem_rsp_valid: pending -= 1; if drop_cnt != 0, discard and drop_cnt -= 1; else push {rsp_pc, imem_rsp_data}, rsp_pc += 4.
REQ-021 Same-cycle request and response: pending unchanged.
REQ-022 out_valid = (count != 0); out_inst/out_pc = FIFO head; pop on out_valid & out_ready.
REQ-023 Same-cycle push and pop: count unchanged, both pointers advance; credit rule (REQ-018) guarantees a push never meets a full FIFO.
REQ-024 Pointers wrap from DEPTH-1 to 0.
REQ-025 redirect_valid (priority over all else): FIFO flushed (count=0, pointers 0), pop ignored; fetch_pc and rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00}; drop_cnt <= pending minus 1 if imem_rsp_valid that cycle; the response in that cycle is discarded; no request issued that cycle.
REQ-026 Redirect while drop_cnt != 0: same rule; drop_cnt recomputed from pending.
REQ-027 out_valid SHALL be 0 the cycle after a redirect; first post-redirect instruction has out_pc = aligned redirect_pc.
REQ-028 Minimum latency: request accepted cycle N, response cycle N+1, out_valid cycle N+2.
REQ-029 Steady state with 1-cycle memory and out_ready=1 SHALL sustain one instruction per cycle.

Reset
REQ-030 rst high: fetch_pc = rsp_pc = RESET_PC, pending = drop_cnt = count = 0, pointers 0, out_valid = 0, imem_req_valid = 0, immediately (asynchronous).
REQ-031 Reset mid-operation discards all buffered and in-flight state; responses for pre-reset requests are not expected after reset.
REQ-032 First cycle after rst deasserts: imem_req_valid = 1, imem_req_addr = RESET_PC.

Verification
REQ-033 Reset, 1-cycle memory, ready=1 -> addrs 0,4,8,...; out_pc 0 at cycle 2, then one per cycle, out_inst matches memory.
REQ-034 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid drops to 0, count=4; out_ready=1 -> drains 0,4,8,12 in order, fetching resumes at 16.
REQ-035 3-cycle memory latency, 3 in flight, redirect_pc=0x103 -> next req addr 0x100; the 3 old responses discarded; first out_pc=0x100.
REQ-036 Redirect in same cycle as a response and a pop -> that response dropped, FIFO empty next cycle, drop_cnt = pending-1.
REQ-037 fetch_pc at 0xFFFFFFFC (XLEN=32) -> next addr 0x00000000; rsp_pc wraps identically.
REQ-038 rst asserted with count=3, pending=1 -> out_valid and imem_req_valid 0 immediately; after release, fetch restarts at RESET_PC.
